// File: rtl/ham_encoder.sv
// Hamming(15,11) encoder feeding a 2-entry output FIFO with a valid/ready handshake on both sides.
// Define HAM_ERR_INJECT_EN to enable single-bit error injection at the accept edge via inject_pos.
module ham_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [11:1]        data_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [15:1]        ham_out,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [3:0]         inject_pos,
  output logic [COUNT_W-1:0] word_count
);

  logic [15:1]        mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [1:0]         count_next;
  logic               in_ready_q;
  logic [COUNT_W-1:0] word_count_q;
  logic [15:1]        encoded;
  logic [15:1]        stored;
  logic               push;
  logic               pop;

  // Codeword positions are numbered 1..15; parity sits at the power-of-two positions.
  always_comb begin
    encoded     = '0;
    encoded[3]  = data_in[1];
    encoded[5]  = data_in[2];
    encoded[6]  = data_in[3];
    encoded[7]  = data_in[4];
    encoded[9]  = data_in[5];
    encoded[10] = data_in[6];
    encoded[11] = data_in[7];
    encoded[12] = data_in[8];
    encoded[13] = data_in[9];
    encoded[14] = data_in[10];
    encoded[15] = data_in[11];
    encoded[1]  = data_in[1] ^ data_in[2] ^ data_in[4] ^ data_in[5] ^ data_in[7] ^ data_in[9] ^ data_in[11];
    encoded[2]  = data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6] ^ data_in[7] ^ data_in[10] ^ data_in[11];
    encoded[4]  = data_in[2] ^ data_in[3] ^ data_in[4] ^ data_in[8] ^ data_in[9] ^ data_in[10] ^ data_in[11];
    encoded[8]  = data_in[5] ^ data_in[6] ^ data_in[7] ^ data_in[8] ^ data_in[9] ^ data_in[10] ^ data_in[11];
  end

`ifdef HAM_ERR_INJECT_EN
  always_comb begin
    stored = encoded;
    if (inject_pos != 4'd0) stored = encoded ^ (15'(1) << (inject_pos - 4'd1));
  end
`else
  // Port kept for pin compatibility; the dangling reduction synthesises away.
  logic unused_inject;
  assign unused_inject = ^inject_pos;
  assign stored        = encoded;
`endif

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (!push && pop) count_next = count - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      in_ready_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr       <= ~rd_ptr;
        word_count_q <= word_count_q + COUNT_W'(1);
      end
      count      <= count_next;
      in_ready_q <= (count_next < 2'd2);
    end
  end

  // NOTE: the storage array is not reset; the occupancy count masks it, so reset only clears pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= stored;
  end

  assign out_valid  = (count != 2'd0);
  assign ham_out    = out_valid ? mem[rd_ptr] : '0;
  assign in_ready   = in_ready_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_ham_encoder.sv
// Randomised and directed bench for ham_encoder against a generic Hamming reference model and decoder.
module tb_ham_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [11:1] data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:1] ham_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  inject_pos = '0;
  logic [15:0] word_count;

  ham_encoder #(.COUNT_W(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ham_out    (ham_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inject_pos (inject_pos),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:1] d;
    logic [3:0]  inj;
  } item_t;

  item_t sb[$];
  int    model_count = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Generic construction: data fills non-power-of-two positions in order, parity p covers positions with bit p set.
  function automatic logic [15:1] ref_encode(input logic [11:1] d);
    logic [15:1] c;
    int k;
    c = '0;
    k = 1;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos & p) != 0) && (pos != p)) par ^= c[pos];
      c[p] = par;
    end
    return c;
  endfunction

  function automatic logic [15:1] ref_fix(input logic [15:1] w);
    logic [15:1] c;
    int syn;
    c = w;
    syn = 0;
    for (int pos = 1; pos <= 15; pos++) if (c[pos]) syn ^= pos;
    if (syn != 0) c[syn] = ~c[syn];
    return c;
  endfunction

  function automatic logic [15:1] exp_word(input item_t it);
    logic [15:1] c;
    c = ref_encode(it.d);
`ifdef HAM_ERR_INJECT_EN
    if (it.inj != 4'd0) c[it.inj] = ~c[it.inj];
`endif
    return c;
  endfunction

  // Called at a falling edge with inputs already driven; checks outputs, updates model, advances one cycle.
  task automatic step();
    bit    do_push;
    bit    do_pop;
    item_t it;
    check("in_ready", in_ready, sb.size() < 2);
    check("out_valid", out_valid, sb.size() != 0);
    check("word_count", word_count, 16'(model_count));
    if (sb.size() != 0) check("head", ham_out, exp_word(sb[0]));
    do_push = in_valid && (sb.size() < 2);
    do_pop  = out_ready && (sb.size() != 0);
    if (do_pop) begin
      it = sb.pop_front();
      check("decoded", ref_fix(ham_out), ref_encode(it.d));
      model_count++;
    end
    if (do_push) sb.push_back('{d: data_in, inj: inject_pos});
    @(negedge clock);
  endtask

  task automatic send_one(input logic [11:1] d, input logic [3:0] inj, input logic [15:1] exp, input string tag);
    data_in    = d;
    inject_pos = inj;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    step();
    in_valid   = 1'b0;
    inject_pos = '0;
    check(tag, ham_out, exp);
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check("drain_empty", out_valid, 1'b0);
  endtask

  int vals[2048];
  int idx;
  int tmp;
  int j;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ham_out", ham_out, 15'h0);
    check("rst_word_count", word_count, 16'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("pre_edge_in_ready", in_ready, 1'b0);
    @(negedge clock);

    send_one(11'h001, 4'd0, 15'h0007, "d001");
    check("d001_count", word_count, 16'd1);
    send_one(11'h400, 4'd0, 15'h408B, "d400");
    send_one(11'h7FF, 4'd0, 15'h7FFF, "d7ff");
    check("directed_count", word_count, 16'd3);

    // Backpressure: third word must be refused while the FIFO is full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 11'h123; step();
    data_in   = 11'h456; step();
    data_in   = 11'h789;
    check("full_in_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("full_head", ham_out, ref_encode(11'h123));
    out_ready = 1'b1;
    step();
    check("second_head", ham_out, ref_encode(11'h456));
    drain();
    check("bp_count", word_count, 16'd5);

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 11'h0AA; step();
    data_in   = 11'h555;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_head", ham_out, ref_encode(11'h555));
    step();
    drain();

`ifdef HAM_ERR_INJECT_EN
    send_one(11'h001, 4'd5, 15'h0017, "inject5");
    check("inject5_fixed", ref_fix(15'h0017), ref_encode(11'h001));
`endif

    // Reset with the FIFO full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 11'h3C3; step();
    data_in   = 11'h2B4; step();
    in_valid  = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_word_count", word_count, 16'h0);
    check("midrst_ham_out", ham_out, 15'h0);
    sb.delete();
    model_count = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("post_rst_pre_edge", in_ready, 1'b0);
    @(negedge clock);
    out_ready = 1'b1;
    step();
    check("no_stale", out_valid, 1'b0);

    // Every data value in shuffled order with random handshakes and random inject positions.
    for (int i = 0; i < 2048; i++) vals[i] = i;
    for (int i = 2047; i > 0; i--) begin
      j = int'($urandom_range(i));
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    idx = 0;
    for (int cyc = 0; cyc < 20000 && model_count < 2048; cyc++) begin
      in_valid   = (idx < 2048) && ($urandom_range(3) != 0);
      data_in    = 11'(vals[idx < 2048 ? idx : 0]);
      inject_pos = 4'($urandom_range(15));
      out_ready  = ($urandom_range(3) != 0);
      if (in_valid && sb.size() < 2) idx++;
      step();
    end
    in_valid   = 1'b0;
    inject_pos = '0;
    check("stream_delivered", word_count, 16'd2048);
    check("stream_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ham_encoder.md
HAM_ENCODER -- requirements
Module: ham_encoder

Interface
REQ-001 SHALL have parameter: COUNT_W, 16, width of encoded-word counter.
REQ-002 SHALL have port: clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: data_in  input  [11:1]  data word to encode.
REQ-005 SHALL have port: in_valid  input  1  data_in valid.
REQ-006 SHALL have port: in_ready  output  1  encoder can accept a word.
REQ-007 SHALL have port: ham_out  output  [15:1]  Hamming(15,11) codeword, head of output queue.
REQ-008 SHALL have port: out_valid  output  1  ham_out valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts ham_out.
REQ-010 SHALL have port: inject_pos  input  [3:0]  bit position to corrupt; 0 = none.
REQ-011 SHALL have port: word_count  output  [COUNT_W-1:0]  codewords delivered.

Function
REQ-012 SHALL accept a word when in_valid && in_ready on a rising clock edge; SHALL push it to a 2-entry output FIFO.
REQ-013 SHALL place data bits as ham[3]=d1, ham[5..7]=d2..d4, ham[9..15]=d5..d11.
REQ-014 SHALL compute parity bits as follows:
- ham[1] = d1^d2^d4^d5^d7^d9^d11
- ham[2] = d1^d3^d4^d6^d7^d10^d11
- ham[4] = d2^d3^d4^d8^d9^d10^d11
- ham[8] = d5^d6^d7^d8^d9^d10^d11
REQ-015 SHALL encode combinationally before the push; latency from accept edge to out_valid high = 1 cycle.
REQ-016 SHALL drive in_ready = (FIFO occupancy < 2), from registered state only, with no combinational path from out_ready.
REQ-017 SHALL pop the head when out_valid && out_ready; ham_out SHALL hold stable while out_valid && !out_ready.
REQ-018 SHALL handle a simultaneous push and pop at occupancy 1 by keeping occupancy at 1, with the new word at the head the next cycle.
REQ-019 SHALL, with the FIFO full, keep in_ready low even if out_ready is high that cycle; in_ready rises the cycle after the pop.
REQ-020 SHALL, when empty, hold out_valid low; ham_out is don't-care.
REQ-021 SHALL increment word_count on each pop and wrap from all-ones to 0.
REQ-022 SHALL keep FIFO pointers modulo 2; no overflow or underflow is possible under the handshake rules.

Reset
REQ-023 SHALL, while reset_n is low, immediately force in_ready=0, out_valid=0, ham_out=0, word_count=0, and empty the FIFO.
REQ-024 SHALL drop any word in flight when reset is asserted mid-transfer; in_ready SHALL rise the first edge after reset_n deasserts.

Configuration
REQ-025 SHALL gate error injection with macro HAM_ERR_INJECT_EN.
REQ-026 SHALL, when HAM_ERR_INJECT_EN is defined and inject_pos is 1..15 at the accept edge, invert that bit of the stored codeword; inject_pos=0 SHALL leave the codeword unchanged.
REQ-027 SHALL, when HAM_ERR_INJECT_EN is undefined, keep the inject_pos port present but ignore it, with no added logic.

Verification
REQ-028 SHALL cover: data_in=11'h001, inject_pos=0, out_ready=1 -> ham_out=15'h0007 one cycle after accept; word_count=1.
REQ-029 SHALL cover: data_in=11'h400 -> ham_out=15'h408B; data_in=11'h7FF -> ham_out=15'h7FFF.
REQ-030 SHALL cover: out_ready=0, push 3 words back-to-back -> in_ready low after 2 accepts; third word not accepted; release out_ready -> words emerge in order.
REQ-031 SHALL cover: all 2048 data values streamed to a hamFix-style decoder -> fixed == encoded word for every value; word_count=2048.
REQ-032 SHALL cover, with HAM_ERR_INJECT_EN defined: data_in=11'h001, inject_pos=5 -> ham_out=15'h0017; decoder output restores 15'h0007.
REQ-033 SHALL cover: reset_n pulsed low with FIFO full -> out_valid=0 and word_count=0 during reset; no stale word after reset.
